// File: rtl/spi_reg_bank.sv
// ============================================================================
// Module   : spi_reg_bank
// Purpose  : SPI command decoder and 8-bit register file behind SPI_Slave.
//            Command byte = {R/W, addr[6:0]}; data bytes follow in the frame.
//            Optional macro SPI_REGS_AUTOINC_EN: advance address per data byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_bank #(
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] ID_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  SPI_CS,
    input  logic                  Rx_DV,
    input  logic [7:0]            Rx_Byte,
    output logic [7:0]            Tx_Byte,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic                  wr_stb,
    output logic [6:0]            wr_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    localparam logic [7:0] c_num_regs  = 8'(NUM_REGS);
    localparam logic [6:0] c_last_addr = 7'(NUM_REGS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cs_sync;
    logic [6:0] r_addr;
    logic [7:0] r_tx_byte;
    logic       r_wr_stb;
    logic [6:0] r_wr_addr;

    logic       w_cs_hi;
    logic       w_cmd_dv;
    logic       w_wr_dv;
    logic       w_rd_dv;
    logic       w_addr_in_rng;
    logic [6:0] w_addr_inc;
    logic [7:0] w_cmd_rdata;
    logic [7:0] w_adv_rdata;

    assign w_cs_hi       = r_cs_sync[1];
    assign w_addr_in_rng = ({1'b0, r_addr} < c_num_regs);

`ifdef SPI_REGS_AUTOINC_EN
    // Out-of-range start addresses keep counting up and only wrap at 127.
    assign w_addr_inc = (r_addr == c_last_addr) ? 7'd0 : r_addr + 7'd1;
`else
    assign w_addr_inc = r_addr;
`endif

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_dv    = 1'b0;
        w_wr_dv     = 1'b0;
        w_rd_dv     = 1'b0;
        // A deasserted CS wins over any byte arriving in the same cycle.
        if (w_cs_hi) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CMD;
                ST_CMD: begin
                    if (Rx_DV) begin
                        w_cmd_dv    = 1'b1;
                        w_state_nxt = Rx_Byte[7] ? ST_WR : ST_RD;
                    end
                end
                ST_WR:   w_wr_dv = Rx_DV;
                ST_RD:   w_rd_dv = Rx_DV;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read muxes: command-byte address and post-advance address
    // ------------------------------------------------------------------------
    always_comb begin
        w_cmd_rdata = 8'h00;
        w_adv_rdata = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (Rx_Byte[6:0] == 7'(i)) begin
                w_cmd_rdata = reg_q[8*i +: 8];
            end
            if (w_addr_inc == 7'(i)) begin
                w_adv_rdata = reg_q[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: CS synchroniser, address pointer, MISO byte, write strobe
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cs_sync <= 2'b11;
            r_addr    <= 7'd0;
            r_tx_byte <= ID_BYTE;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= 7'd0;
        end else begin
            r_cs_sync <= {r_cs_sync[0], SPI_CS};
            r_wr_stb  <= 1'b0;
            if (w_cs_hi || (r_state == ST_IDLE)) begin
                r_tx_byte <= ID_BYTE;
            end
            if (w_cmd_dv) begin
                r_addr    <= Rx_Byte[6:0];
                r_tx_byte <= Rx_Byte[7] ? 8'h00 : w_cmd_rdata;
            end
            if (w_wr_dv) begin
                r_addr <= w_addr_inc;
                if (w_addr_in_rng) begin
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_addr;
                end
            end
            if (w_rd_dv) begin
                r_addr    <= w_addr_inc;
                r_tx_byte <= w_adv_rdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [6:0] c_idx = 7'(gi);
        logic [7:0] r_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_q <= 8'h00;
            end else if (w_wr_dv && (r_addr == c_idx)) begin
                r_q <= Rx_Byte;
            end
        end

        assign reg_q[8*gi +: 8] = r_q;
    end

    assign Tx_Byte = r_tx_byte;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;

endmodule

`default_nettype wire
